// File: rtl/gate_pkg.sv
// Shared definitions for the gate supervisor.
// - gate_state_t : FSM state encoding, also exported on state_o for debug.
// - timer_width  : width of the shared saturating timer, sized to hold the
//                  largest cycle parameter.
package gate_pkg;

  typedef enum logic [2:0] {
    STOPPED = 3'd0,
    CLOSED  = 3'd1,
    OPENING = 3'd2,
    OPEN    = 3'd3,
    CLOSING = 3'd4,
    PAUSE   = 3'd5,
    FAULT   = 3'd6
  } gate_state_t;

  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gate_btn_debounce.sv
// Push-button debouncer.
// - clk_i       : clock, rising edge
// - rst_i       : synchronous reset, active-high; leaves the debouncer disarmed
// - btn_i       : raw button, already synchronous to clk_i
// - btn_pulse_o : one-cycle pulse after DEB_CYCLES consecutive high samples
// A held button yields a single pulse; a low sample is needed to re-arm.
module gate_btn_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_pulse_o
);

  localparam int unsigned   CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          pulse_q, pulse_d;

  // cnt_q holds the number of high samples already seen; the sample that
  // finds it at CNT_LAST is the DEB_CYCLES-th one.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    pulse_d = 1'b0;
    if (!btn_i) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      if (armed_q) begin
        pulse_d = 1'b1;
        armed_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_pulse_o = pulse_q;

endmodule

// File: rtl/gate_supervisor.sv
// Gate motor supervisory FSM.
// - clk_i, rst_i : clock and synchronous active-high reset
// - btn_i        : push button (debounced internally)
// - fca_i/fcc_i  : fully-open / fully-closed limit switches
// - obst_i       : photocell, 1 = beam blocked
// - auto_en_i    : enables auto-close from OPEN
// - abrir_o      : open command (OPENING only)
// - fechar_o     : close command (CLOSING only)
// - fault_o      : sticky fault flag (FAULT only)
// - state_o      : state register, for debug
// Motor reversals go through PAUSE for a motor-off dead time; the
// reversal target is kept in to_open_q.
import gate_pkg::*;

module gate_supervisor #(
  parameter int unsigned DEB_CYCLES        = 4,
  parameter int unsigned AUTO_CLOSE_CYCLES = 100,
  parameter int unsigned TRAVEL_MAX_CYCLES = 200,
  parameter int unsigned REV_PAUSE_CYCLES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  input  logic       fca_i,
  input  logic       fcc_i,
  input  logic       obst_i,
  input  logic       auto_en_i,
  output logic       abrir_o,
  output logic       fechar_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam int unsigned TW = timer_width(DEB_CYCLES, AUTO_CLOSE_CYCLES,
                                           TRAVEL_MAX_CYCLES, REV_PAUSE_CYCLES);
  localparam logic [TW-1:0] AUTO_LAST   = TW'(AUTO_CLOSE_CYCLES - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_MAX_CYCLES - 1);
  localparam logic [TW-1:0] PAUSE_LAST  = TW'(REV_PAUSE_CYCLES - 1);

  gate_state_t   state_q, state_d;
  logic          to_open_q, to_open_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          btn_pulse;

  gate_btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .btn_i      (btn_i),
    .btn_pulse_o(btn_pulse)
  );

  always_comb begin
    state_d   = state_q;
    to_open_d = to_open_q;
    if (state_q != FAULT && fca_i && fcc_i) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        STOPPED: begin
          if (fcc_i)          state_d = CLOSED;
          else if (fca_i)     state_d = OPEN;
          else if (btn_pulse) state_d = OPENING;
        end
        CLOSED: begin
          if (btn_pulse) state_d = OPENING;
        end
        OPENING: begin
          if (fca_i)                      state_d = OPEN;
          else if (timer_q == TRAVEL_LAST) state_d = FAULT;
          else if (btn_pulse) begin
            state_d   = PAUSE;
            to_open_d = 1'b0;
          end
        end
        OPEN: begin
          if (btn_pulse) state_d = CLOSING;
          else if (auto_en_i && !obst_i && timer_q == AUTO_LAST) state_d = CLOSING;
        end
        CLOSING: begin
          if (fcc_i) state_d = CLOSED;
          else if (obst_i || btn_pulse) begin
            state_d   = PAUSE;
            to_open_d = 1'b1;
          end else if (timer_q == TRAVEL_LAST) state_d = FAULT;
        end
        PAUSE: begin
          if (timer_q == PAUSE_LAST) state_d = to_open_q ? OPENING : CLOSING;
        end
        FAULT:   state_d = FAULT;
        default: state_d = STOPPED;
      endcase
    end

    // Shared timer: restarts on any state change and while the beam is
    // blocked in OPEN; saturates so a long idle never wraps into a match.
    if (state_d != state_q || (state_q == OPEN && obst_i)) timer_d = '0;
    else if (timer_q != '1)                                timer_d = timer_q + 1'b1;
    else                                                   timer_d = timer_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= STOPPED;
      to_open_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      to_open_q <= to_open_d;
      timer_q   <= timer_d;
    end
  end

  assign abrir_o  = (state_q == OPENING);
  assign fechar_o = (state_q == CLOSING);
  assign fault_o  = (state_q == FAULT);
  assign state_o  = state_q;

endmodule

// File: tb/tb_gate_supervisor.sv
module tb_gate_supervisor;

  localparam int DEB    = 2;
  localparam int AUTO   = 10;
  localparam int TRAVEL = 20;
  localparam int REV    = 3;

  localparam int M_STOPPED = 0, M_CLOSED = 1, M_OPENING = 2, M_OPEN = 3,
                 M_CLOSING = 4, M_PAUSE = 5, M_FAULT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1, btn = 1'b0, fca = 1'b0, fcc = 1'b0, obst = 1'b0, auto_en = 1'b0;
  logic       abrir_o, fechar_o, fault_o;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: gate phase, cycles since entering it (unbounded),
  // button run length, debouncer arm flag, pending pulse, reversal target.
  int m_st = M_STOPPED, m_age = 0, m_run = 0;
  bit m_armed = 0, m_pulse = 0, m_to_open = 0;

  gate_supervisor #(
    .DEB_CYCLES       (DEB),
    .AUTO_CLOSE_CYCLES(AUTO),
    .TRAVEL_MAX_CYCLES(TRAVEL),
    .REV_PAUSE_CYCLES (REV)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_i    (btn),
    .fca_i    (fca),
    .fcc_i    (fcc),
    .obst_i   (obst),
    .auto_en_i(auto_en),
    .abrir_o  (abrir_o),
    .fechar_o (fechar_o),
    .fault_o  (fault_o),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  nxt;
    bit  fired;
    if (rst) begin
      m_st = M_STOPPED; m_age = 0; m_run = 0;
      m_armed = 0; m_pulse = 0; m_to_open = 0;
      return;
    end
    nxt = m_st;
    if (m_st != M_FAULT && fca && fcc) nxt = M_FAULT;
    else begin
      case (m_st)
        M_STOPPED: if (fcc) nxt = M_CLOSED; else if (fca) nxt = M_OPEN;
                   else if (m_pulse) nxt = M_OPENING;
        M_CLOSED:  if (m_pulse) nxt = M_OPENING;
        M_OPENING: if (fca) nxt = M_OPEN; else if (m_age == TRAVEL - 1) nxt = M_FAULT;
                   else if (m_pulse) begin nxt = M_PAUSE; m_to_open = 0; end
        M_OPEN:    if (m_pulse || (auto_en && !obst && m_age == AUTO - 1)) nxt = M_CLOSING;
        M_CLOSING: if (fcc) nxt = M_CLOSED;
                   else if (obst || m_pulse) begin nxt = M_PAUSE; m_to_open = 1; end
                   else if (m_age == TRAVEL - 1) nxt = M_FAULT;
        M_PAUSE:   if (m_age == REV - 1) nxt = m_to_open ? M_OPENING : M_CLOSING;
        default:   nxt = m_st;
      endcase
    end
    m_age   = (nxt != m_st || (m_st == M_OPEN && obst)) ? 0 : m_age + 1;
    m_st    = nxt;
    m_run   = btn ? m_run + 1 : 0;
    fired   = btn && m_armed && (m_run >= DEB);
    m_pulse = fired;
    m_armed = !btn ? 1'b1 : (fired ? 1'b0 : m_armed);
  endtask

  // One clock: advance model, then compare all outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check($sformatf("state@%0d", cyc),  state_o,  m_st);
    check($sformatf("abrir@%0d", cyc),  abrir_o,  m_st == M_OPENING);
    check($sformatf("fechar@%0d", cyc), fechar_o, m_st == M_CLOSING);
    check($sformatf("fault@%0d", cyc),  fault_o,  m_st == M_FAULT);
    check($sformatf("excl@%0d", cyc),   abrir_o & fechar_o, 0);
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (DEB) tick();
    btn = 1'b0;
  endtask

  initial begin
    int         changes;
    logic [2:0] prev;

    // 1. reset into CLOSED, press to open, limit switch stops it
    rst = 1'b1; fcc = 1'b1; tick();
    check("t1_reset_state", state_o, M_STOPPED);
    check("t1_reset_abrir", abrir_o, 0);
    check("t1_reset_fault", fault_o, 0);
    rst = 1'b0; tick();
    check("t1_closed", state_o, M_CLOSED);
    btn = 1'b1; tick(); tick();
    check("t1_abrir_not_yet", abrir_o, 0);
    btn = 1'b0; fcc = 1'b0; tick();
    check("t1_abrir_3rd_edge", abrir_o, 1);
    fca = 1'b1; tick();
    check("t1_abrir_off", abrir_o, 0);
    check("t1_open", state_o, M_OPEN);

    // 2. auto-close after 10 cycles; obstacle pulse restarts the count
    fca = 1'b0; auto_en = 1'b1;
    repeat (AUTO - 1) tick();
    check("t2_fechar_early", fechar_o, 0);
    tick();
    check("t2_fechar_rise", fechar_o, 1);
    fcc = 1'b1; tick(); fcc = 1'b0;
    press(); tick();
    fca = 1'b1; tick(); fca = 1'b0;
    check("t2_open_again", state_o, M_OPEN);
    repeat (4) tick();
    obst = 1'b1; tick(); obst = 1'b0;
    repeat (AUTO - 1) tick();
    check("t2_obst_delay", fechar_o, 0);
    tick();
    check("t2_obst_rise", fechar_o, 1);

    // 3. obstacle reversal while closing, then button reversal while opening
    obst = 1'b1; tick(); obst = 1'b0;
    check("t3_fechar_off", fechar_o, 0);
    check("t3_pause", state_o, M_PAUSE);
    tick(); tick();
    check("t3_dead_abrir", abrir_o, 0);
    check("t3_dead_fechar", fechar_o, 0);
    tick();
    check("t3_abrir_on", abrir_o, 1);
    press(); tick();
    check("t3m_pause", state_o, M_PAUSE);
    tick(); tick();
    check("t3m_dead", {abrir_o, fechar_o}, 0);
    tick();
    check("t3m_fechar_on", fechar_o, 1);

    // 4. travel timeout, fault is sticky until reset
    obst = 1'b1; tick(); obst = 1'b0;
    repeat (REV) tick();
    check("t4_opening", abrir_o, 1);
    auto_en = 1'b0;
    repeat (TRAVEL - 1) tick();
    check("t4_no_fault_yet", fault_o, 0);
    tick();
    check("t4_fault", fault_o, 1);
    check("t4_motors_off", {abrir_o, fechar_o}, 0);
    press(); press(); repeat (3) tick();
    fca = 1'b1; fcc = 1'b1; tick(); fca = 1'b0; fcc = 1'b0;
    check("t4_fault_sticky", state_o, M_FAULT);
    rst = 1'b1; tick();
    check("t4_rst_fault", fault_o, 0);
    check("t4_rst_state", state_o, M_STOPPED);
    rst = 1'b0; tick();

    // 5. sensor conflict and reset mid-travel
    fcc = 1'b1; tick();
    check("t5_closed", state_o, M_CLOSED);
    fca = 1'b1; tick();
    check("t5_conflict", state_o, M_FAULT);
    fca = 1'b0; fcc = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; fcc = 1'b1; tick(); fcc = 1'b0;
    press(); tick();
    check("t5_opening", abrir_o, 1);
    press(); tick(); repeat (REV) tick();
    check("t5_closing", fechar_o, 1);
    rst = 1'b1; tick();
    check("t5_rst_fechar", fechar_o, 0);
    check("t5_rst_state", state_o, M_STOPPED);
    rst = 1'b0; tick();
    check("t5_stopped", state_o, M_STOPPED);

    // 6. held button gives one press; saturated timer never auto-closes
    fcc = 1'b1; tick(); fcc = 1'b0;
    btn = 1'b1; changes = 0; prev = state_o;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) fca = 1'b1;
      tick();
      if (state_o != prev) changes++;
      prev = state_o;
    end
    check("t6_transitions", changes, 2);
    check("t6_held_open", state_o, M_OPEN);
    auto_en = 1'b1;
    repeat (15) tick();
    check("t6_sat_no_autoclose", state_o, M_OPEN);
    auto_en = 1'b0; btn = 1'b0; fca = 1'b0; tick();
    press(); tick();
    check("t6_closing", state_o, M_CLOSING);
    press(); tick();
    check("t6_pause", state_o, M_PAUSE);

    // Randomized traffic against the model
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) btn = ~btn;
      fca  = ($urandom_range(0, 11) == 0);
      fcc  = ($urandom_range(0, 11) == 0);
      obst = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) auto_en = ~auto_en;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
